// File: rtl/spi_target_pkg.sv
// spi_target_pkg
//   Shared definitions for the SPI target register interface: default
//   address/data widths, command encodings, the frame FSM state type and a
//   command-validity helper.
package spi_target_pkg;

  localparam int SPI_ADDR_WIDTH = 3;
  localparam int SPI_DATA_WIDTH = 18;

  localparam logic [1:0] CMD_WR = 2'b10;
  localparam logic [1:0] CMD_RD = 2'b01;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    TURN = 3'd3,
    DATA = 3'd4,
    DONE = 3'd5
  } spi_tgt_state_e;

  // Only the two defined command codes start a register access.
  function automatic logic cmd_is_valid(input logic [1:0] cmd);
    return (cmd == CMD_WR) || (cmd == CMD_RD);
  endfunction

endpackage

// File: rtl/spi_target_regif_sync.sv
// spi_sync_edge
//   Two-flop synchronizer for one asynchronous SPI pin, followed by a history
//   flop used to produce single-cycle rise/fall pulses.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   din  in  asynchronous pin
//   sync out synchronized level
//   rise out one-cycle pulse on a synchronized 0->1 transition
//   fall out one-cycle pulse on a synchronized 1->0 transition
// All flops reset to 0; a chip select already low at reset release therefore
// never produces a falling edge, which keeps a half-seen frame from starting.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain plus edge-history register
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign sync = sync_r;
  assign rise = sync_r & ~prev_r;
  assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/spi_target_regif.sv
// spi_target_regif
//   SPI mode-0 target that turns {cmd[1:0], addr[AW-1:0], turnaround, data}
//   frames into single-cycle register write/read strobes. SPI pins are
//   oversampled on clk (clk >= 8x SCK).
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   spi_sck, spi_csn, spi_mosi  SPI inputs (asynchronous)
//   spi_miso                    read data to host, 0 when not driving
//   reg_wr_en/addr/data         one-cycle write strobe with address and data
//   reg_rd_en/addr              one-cycle read strobe with address
//   reg_rd_data                 read data, valid one cycle after reg_rd_en
//   frame_err                   one-cycle pulse on an aborted/invalid frame
module spi_target_regif
  import spi_target_pkg::*;
#(
  parameter int AW = SPI_ADDR_WIDTH,
  parameter int DW = SPI_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_sck,
  input  logic          spi_csn,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          reg_wr_en,
  output logic [AW-1:0] reg_wr_addr,
  output logic [DW-1:0] reg_wr_data,
  output logic          reg_rd_en,
  output logic [AW-1:0] reg_rd_addr,
  input  logic [DW-1:0] reg_rd_data,
  output logic          frame_err
);

  localparam int CW = $clog2(AW + DW + 32'd4);
  localparam logic [CW-1:0] CNT_ONE       = CW'(32'd1);
  localparam logic [CW-1:0] CNT_CMD_LAST  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ADDR_LAST = CW'(AW + 32'd1);
  localparam logic [CW-1:0] CNT_DATA_LAST = CW'(AW + DW + 32'd2);

  logic sck_sync_s, sck_rise_s, sck_fall_s;
  logic csn_sync_s, csn_rise_s, csn_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic bit_s;
  logic unused_s;
  logic [DW-1:0] rx_next_s;

  spi_tgt_state_e state_r;
  logic [CW-1:0]  bcnt_r;
  logic [DW-2:0]  rx_sh_r;
  logic [DW-1:0]  tx_sh_r;
  logic [1:0]     cmd_r;
  logic [AW-1:0]  addr_r;
  logic           rd_load_r;

  spi_sync_edge u_sck (.clk(clk), .rst(rst), .din(spi_sck),
                       .sync(sck_sync_s), .rise(sck_rise_s), .fall(sck_fall_s));
  spi_sync_edge u_csn (.clk(clk), .rst(rst), .din(spi_csn),
                       .sync(csn_sync_s), .rise(csn_rise_s), .fall(csn_fall_s));
  spi_sync_edge u_mosi (.clk(clk), .rst(rst), .din(spi_mosi),
                        .sync(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s));

  // SCK level and MOSI edges have no consumer.
  assign unused_s = ^{sck_sync_s, mosi_rise_s, mosi_fall_s};

  // A bit is sampled on each synchronized SCK rise while CSN is low.
  assign bit_s     = sck_rise_s & ~csn_sync_s;
  assign rx_next_s = {rx_sh_r, mosi_s};

  // Frame FSM, bit counter, RX/TX shift registers and register-bus strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      bcnt_r      <= '0;
      rx_sh_r     <= '0;
      tx_sh_r     <= '0;
      cmd_r       <= 2'b00;
      addr_r      <= '0;
      rd_load_r   <= 1'b0;
      spi_miso    <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      reg_rd_en   <= 1'b0;
      reg_rd_addr <= '0;
      frame_err   <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
      // Read data arrives one cycle after the strobe; capture it then.
      rd_load_r <= reg_rd_en;
      if (rd_load_r) begin
        tx_sh_r <= reg_rd_data;
      end
      if (csn_rise_s) begin
        // CSN high ends any frame; only a frame cut short is an error.
        frame_err <= (state_r != IDLE) && (state_r != DONE);
        state_r   <= IDLE;
        bcnt_r    <= '0;
        spi_miso  <= 1'b0;
      end else begin
        if (bit_s && (state_r != IDLE) && (state_r != DONE)) begin
          rx_sh_r <= rx_next_s[DW-2:0];
          bcnt_r  <= bcnt_r + CNT_ONE;
        end
        case (state_r)
          IDLE: begin
            // CSN fall takes effect first; a coincident SCK rise is bit 0.
            if (csn_fall_s) begin
              state_r <= CMD;
              if (sck_rise_s) begin
                rx_sh_r <= {{(DW-2){1'b0}}, mosi_s};
                bcnt_r  <= CNT_ONE;
              end else begin
                rx_sh_r <= '0;
                bcnt_r  <= '0;
              end
            end
          end
          CMD: begin
            if (bit_s && (bcnt_r == CNT_CMD_LAST)) begin
              cmd_r <= rx_next_s[1:0];
              if (cmd_is_valid(rx_next_s[1:0])) begin
                state_r <= ADDR;
              end else begin
                frame_err <= 1'b1;
                state_r   <= DONE;
              end
            end
          end
          ADDR: begin
            if (bit_s && (bcnt_r == CNT_ADDR_LAST)) begin
              addr_r  <= rx_next_s[AW-1:0];
              state_r <= TURN;
              if (cmd_r == CMD_RD) begin
                reg_rd_en   <= 1'b1;
                reg_rd_addr <= rx_next_s[AW-1:0];
              end
            end
          end
          TURN: begin
            if (bit_s) begin
              state_r <= DATA;
            end
          end
          DATA: begin
            // First fall in DATA presents the MSB; later falls shift.
            if (sck_fall_s && (cmd_r == CMD_RD)) begin
              spi_miso <= tx_sh_r[DW-1];
              tx_sh_r  <= {tx_sh_r[DW-2:0], 1'b0};
            end
            if (bit_s && (bcnt_r == CNT_DATA_LAST)) begin
              state_r <= DONE;
              if (cmd_r == CMD_WR) begin
                reg_wr_en   <= 1'b1;
                reg_wr_addr <= addr_r;
                reg_wr_data <= rx_next_s;
              end
            end
          end
          DONE: begin
            // Extra SCK activity is ignored until CSN rises.
            spi_miso <= 1'b0;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_target_regif.sv
// tb_spi_target_regif
//   Self-checking bench: a mode-0 host drives frames, a register-file model
//   answers reads, and monitors collect strobes into queues that each test
//   task compares against the expectations it pushed when driving stimulus.
module tb_spi_target_regif;
  import spi_target_pkg::*;

  localparam int AW   = 3;
  localparam int DW   = 18;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          spi_sck, spi_csn, spi_mosi, spi_miso;
  logic          reg_wr_en, reg_rd_en, frame_err;
  logic [AW-1:0] reg_wr_addr, reg_rd_addr;
  logic [DW-1:0] reg_wr_data, reg_rd_data;

  spi_target_regif #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_csn(spi_csn),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0]    mem [0:7];
  logic [AW+DW-1:0] obs_wr_q[$], exp_wr_q[$];
  logic [AW-1:0]    obs_rd_q[$], exp_rd_q[$];
  logic [DW-1:0]    exp_rx_q[$];
  int               err_cnt, miso_hi_cnt, both_cnt;

  // Strobe monitor and register-file write model
  always @(negedge clk) begin
    if (reg_wr_en) begin
      obs_wr_q.push_back({reg_wr_addr, reg_wr_data});
      mem[reg_wr_addr] = reg_wr_data;
    end
    if (reg_rd_en) obs_rd_q.push_back(reg_rd_addr);
    if (reg_wr_en && reg_rd_en) both_cnt++;
    if (frame_err) err_cnt++;
    if (spi_miso) miso_hi_cnt++;
  end

  // Register-file read port: data valid exactly one cycle after the strobe
  always @(posedge clk) begin
    reg_rd_data <= reg_rd_en ? mem[reg_rd_addr] : 18'h3FFFF;
  end

  task automatic clear_sb();
    obs_wr_q.delete(); exp_wr_q.delete();
    obs_rd_q.delete(); exp_rd_q.delete(); exp_rx_q.delete();
    err_cnt = 0; miso_hi_cnt = 0; both_cnt = 0;
  endtask

  // Host-side frame: nbits bits of {cmd, addr, 0, data}, extra SCK pulses,
  // optional reset pulse before bit rst_at; rx collects MISO on data rises.
  task automatic spi_frame(input logic [1:0] cmd, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input int nbits,
                           input int extra, input int rst_at,
                           output logic [DW-1:0] rx);
    logic [23:0] fr;
    fr = {cmd, addr, 1'b0, data};
    rx = '0;
    @(negedge clk);
    spi_csn = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      spi_mosi = fr[23-i];
      repeat (HALF) @(negedge clk);
      if (i >= AW + 3) rx = {rx[DW-2:0], spi_miso};
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
    for (int k = 0; k < extra; k++) begin
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_csn  = 1'b1;
    spi_mosi = 1'b0;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    spi_csn = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({spi_miso, reg_wr_en, reg_rd_en, frame_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0000", {spi_miso, reg_wr_en, reg_rd_en, frame_err});
    end
    vectors++;
    if ({reg_wr_addr, reg_wr_data, reg_rd_addr} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_bus: got %h want 0", {reg_wr_addr, reg_wr_data, reg_rd_addr});
    end
    rst = 1'b0;
    clear_sb();
    repeat (10) @(negedge clk);
    vectors++;
    if (err_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_idle_err: got %0d pulses want 0", err_cnt);
    end
  endtask

  task automatic test_single_write();
    logic [DW-1:0] rx;
    logic [AW+DW-1:0] e, o;
    clear_sb();
    exp_wr_q.push_back({3'd0, 18'h10101});
    spi_frame(CMD_WR, 3'd0, 18'h10101, 24, 0, -1, rx);
    vectors++;
    if (obs_wr_q.size() !== exp_wr_q.size()) begin
      miscompares++;
      $display("FAIL single_wr_count: got %0d want %0d", obs_wr_q.size(), exp_wr_q.size());
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL single_wr: got %h want %h", o, e);
      end
    end
    vectors++;
    if (err_cnt !== 0) begin
      miscompares++;
      $display("FAIL single_wr_err: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rx, ex;
    logic [AW+DW-1:0] e, o;
    logic [AW-1:0] ea, oa;
    clear_sb();
    for (int i = 0; i < 8; i++) begin
      exp_wr_q.push_back({3'(i), 18'h10101 + 18'(i)});
      spi_frame(CMD_WR, 3'(i), 18'h10101 + 18'(i), 24, 0, -1, rx);
    end
    vectors++;
    if (obs_wr_q.size() !== 8) begin
      miscompares++;
      $display("FAIL b2b_wr_count: got %0d want 8", obs_wr_q.size());
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL b2b_wr: got %h want %h", o, e);
      end
    end
    for (int i = 0; i < 8; i++) begin
      exp_rd_q.push_back(3'(i));
      exp_rx_q.push_back(18'h10101 + 18'(i));
      spi_frame(CMD_RD, 3'(i), 18'h00000, 24, 0, -1, rx);
      ex = exp_rx_q.pop_front(); vectors++;
      if (rx !== ex) begin
        miscompares++;
        $display("FAIL b2b_rd_data[%0d]: got %h want %h", i, rx, ex);
      end
      ea = exp_rd_q.pop_front(); vectors++;
      if (obs_rd_q.size() !== 1) begin
        miscompares++;
        $display("FAIL b2b_rd_count[%0d]: got %0d want 1", i, obs_rd_q.size());
      end else begin
        oa = obs_rd_q.pop_front();
        if (oa !== ea) begin
          miscompares++;
          $display("FAIL b2b_rd_addr[%0d]: got %0d want %0d", i, oa, ea);
        end
      end
      obs_rd_q.delete();
    end
    vectors++;
    if (obs_wr_q.size() !== 0 || both_cnt !== 0 || err_cnt !== 0) begin
      miscompares++;
      $display("FAIL b2b_side: got wr=%0d both=%0d err=%0d want 0/0/0", obs_wr_q.size(), both_cnt, err_cnt);
    end
  endtask

  task automatic test_bad_cmd();
    logic [DW-1:0] rx;
    clear_sb();
    spi_frame(2'b11, 3'd5, 18'h3FFFF, 24, 0, -1, rx);
    vectors++;
    if (obs_wr_q.size() !== 0 || obs_rd_q.size() !== 0) begin
      miscompares++;
      $display("FAIL bad_cmd_strobe: got wr=%0d rd=%0d want 0/0", obs_wr_q.size(), obs_rd_q.size());
    end
    vectors++;
    if (miso_hi_cnt !== 0) begin
      miscompares++;
      $display("FAIL bad_cmd_miso: got %0d high cycles want 0", miso_hi_cnt);
    end
    vectors++;
    if (err_cnt !== 1) begin
      miscompares++;
      $display("FAIL bad_cmd_err: got %0d want 1", err_cnt);
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] rx;
    logic [AW+DW-1:0] e, o;
    clear_sb();
    spi_frame(CMD_WR, 3'd2, 18'h12345, 10, 0, -1, rx);
    vectors++;
    if (obs_wr_q.size() !== 0 || err_cnt !== 1) begin
      miscompares++;
      $display("FAIL abort: got wr=%0d err=%0d want 0/1", obs_wr_q.size(), err_cnt);
    end
    clear_sb();
    exp_wr_q.push_back({3'd3, 18'h2ABCD});
    spi_frame(CMD_WR, 3'd3, 18'h2ABCD, 24, 0, -1, rx);
    vectors++;
    if (obs_wr_q.size() !== 1 || err_cnt !== 0) begin
      miscompares++;
      $display("FAIL abort_next_count: got wr=%0d err=%0d want 1/0", obs_wr_q.size(), err_cnt);
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL abort_next_wr: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rx;
    logic [AW+DW-1:0] e, o;
    clear_sb();
    spi_frame(CMD_WR, 3'd5, 18'h3C3C3, 24, 0, 15, rx);
    vectors++;
    if ({reg_wr_en, reg_rd_en, frame_err, spi_miso, reg_wr_addr, reg_wr_data, reg_rd_addr} !== 28'h0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got wa=%0d wd=%h ra=%0d want 0", reg_wr_addr, reg_wr_data, reg_rd_addr);
    end
    vectors++;
    if (obs_wr_q.size() !== 0 || obs_rd_q.size() !== 0 || err_cnt !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_strobe: got wr=%0d rd=%0d err=%0d want 0/0/0", obs_wr_q.size(), obs_rd_q.size(), err_cnt);
    end
    clear_sb();
    exp_wr_q.push_back({3'd7, 18'h00001});
    spi_frame(CMD_WR, 3'd7, 18'h00001, 24, 0, -1, rx);
    vectors++;
    if (obs_wr_q.size() !== 1) begin
      miscompares++;
      $display("FAIL rst_mid_next_count: got %0d want 1", obs_wr_q.size());
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL rst_mid_next_wr: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_extra_sck();
    logic [DW-1:0] rx;
    logic [AW+DW-1:0] e, o;
    clear_sb();
    exp_wr_q.push_back({3'd6, 18'h15555});
    spi_frame(CMD_WR, 3'd6, 18'h15555, 24, 5, -1, rx);
    vectors++;
    if (obs_wr_q.size() !== 1 || err_cnt !== 0) begin
      miscompares++;
      $display("FAIL extra_sck_count: got wr=%0d err=%0d want 1/0", obs_wr_q.size(), err_cnt);
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL extra_sck_wr: got %h want %h", o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_bad_cmd();
    test_abort();
    test_reset_mid();
    test_extra_sck();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
